// File: rtl/prog_loader_pkg.sv
// Shared definitions for the host-side program loader: FSM encoding, byte width
// and default dump window.
package prog_loader_pkg;

    localparam int BYTE_W = 8;

    localparam logic [7:0] DEF_DUMP_BASE = 8'hF0;
    localparam int         DEF_DUMP_LEN  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DUMP_RD,
        ST_DUMP_WAIT,
        ST_DUMP_TX
    } ld_state_e;

endpackage

// File: rtl/prog_loader_byte_skid_reg.sv
// One-entry valid/ready holding register; keeps the byte stable while the
// consumer stalls.
module byte_skid_reg
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Host-side loader: streams a length-prefixed program into RAM, releases the CPU,
// waits for finish (or watchdog), then returns a fixed RAM window to the host.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                RD_LAT    = 1,
    parameter logic [ADDR_W-1:0] DUMP_BASE = ADDR_W'(DEF_DUMP_BASE),
    parameter int                DUMP_LEN  = DEF_DUMP_LEN,
    parameter int unsigned       TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [BYTE_W-1:0] mem_rdata,
    input  logic              finish,
    output logic              cpu_hold,
    output logic              busy,
    output logic              timeout_err
);

    ld_state_e         state;
    logic [8:0]        idx;
    logic [7:0]        last_idx;
    logic [31:0]       run_cnt;
    logic [RD_LAT:0]   vld_pipe;
    logic              skid_in_ready;
    logic              capture;
    logic [ADDR_W-1:0] dump_addr, dump_addr_nxt;

    // vld_pipe[0] is the read strobe itself; bit RD_LAT marks valid read data.
    assign mem_re        = vld_pipe[0];
    assign busy          = (state != ST_IDLE);
    assign capture       = (state == ST_DUMP_WAIT) && vld_pipe[RD_LAT];
    assign dump_addr     = DUMP_BASE + ADDR_W'(idx);
    assign dump_addr_nxt = DUMP_BASE + ADDR_W'(idx + 9'd1);

    byte_skid_reg u_tx (
        .clk       (clk),
        .rst       (rst),
        .in_data   (mem_rdata),
        .in_valid  (capture),
        .in_ready  (skid_in_ready),
        .out_data  (tx_data),
        .out_valid (tx_valid),
        .out_ready (tx_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cpu_hold    <= 1'b1;
            rx_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            vld_pipe    <= '0;
            timeout_err <= 1'b0;
            idx         <= '0;
            last_idx    <= '0;
            run_cnt     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LAT-1:0], 1'b0};
            mem_we   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    rx_ready <= 1'b1;
                    if (rx_valid && rx_ready) begin
                        // length 0 wraps to last index 255, i.e. 256 bytes
                        last_idx    <= rx_data - 8'd1;
                        idx         <= '0;
                        timeout_err <= 1'b0;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!rx_ready) begin
                        // final write is on the port this cycle; release next
                        state    <= ST_RUN;
                        cpu_hold <= 1'b0;
                        run_cnt  <= '0;
                        idx      <= '0;
                    end else if (rx_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ADDR_W'(idx);
                        mem_wdata <= rx_data;
                        idx       <= idx + 9'd1;
                        if (idx[7:0] == last_idx) rx_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (finish || (TIMEOUT != 0 && run_cnt + 32'd1 == TIMEOUT)) begin
                        timeout_err <= !finish;
                        cpu_hold    <= 1'b1;
                        vld_pipe[0] <= 1'b1;
                        mem_addr    <= dump_addr;
                        state       <= ST_DUMP_RD;
                    end else begin
                        run_cnt <= run_cnt + 32'd1;
                    end
                end
                ST_DUMP_RD: state <= ST_DUMP_WAIT;
                ST_DUMP_WAIT: begin
                    if (capture && skid_in_ready) state <= ST_DUMP_TX;
                end
                ST_DUMP_TX: begin
                    if (tx_valid && tx_ready) begin
                        if (idx + 9'd1 == 9'(DUMP_LEN)) begin
                            state    <= ST_IDLE;
                            rx_ready <= 1'b1;
                        end else begin
                            idx         <= idx + 9'd1;
                            vld_pipe[0] <= 1'b1;
                            mem_addr    <= dump_addr_nxt;
                            state       <= ST_DUMP_RD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
